i2c_master_engine: RTL and testbench

- Byte-level I2C master that issues the team's register-access transactions toward the I2C slave serial interface.
- Write transaction on the bus: START, devAddr+W, regAddr, dataLen, then dataLen data bytes, STOP.
- Read transaction on the bus: START, devAddr+W, regAddr, dataLen, repeated START, devAddr+R, then dataLen data bytes, STOP.
- Sits between a host command port and the open-drain SCL/SDA pads. The pads are driven low when the corresponding output is 0 and released when it is 1.

---
 rtl/i2c_master_engine.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_i2c_master_engine.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master_engine.sv
// Byte-level I2C master for register write/read transactions on open-drain SCL/SDA.
// Define I2C_MASTER_STRETCH_EN to honour slave clock stretching via sclIn.
module i2c_master_engine #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] devAddr,
    input  logic [7:0] regAddr,
    input  logic [7:0] dataLen,
    input  logic [7:0] txData,
    output logic       txAck,
    output logic [7:0] rxData,
    output logic       rxValid,
    output logic       busy,
    output logic       done,
    output logic       ackErr,
    input  logic       sclIn,
    input  logic       sdaIn,
    output logic       sclOut,
    output logic       sdaOut
);

    localparam logic [9:0] QuarterMax = 10'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        StIdle, StStart, StAddrW, StReg, StLen, StWdata, StRstart, StAddrR, StRdata, StStop
    } state_e;

    state_e     stateQ, stateD;
    logic [1:0] phaseQ, phaseD;
    logic [9:0] qCntQ, qCntD;
    logic [3:0] bitCntQ, bitCntD;
    logic [7:0] byteCntQ, byteCntD;
    logic [7:0] shiftQ, shiftD;
    logic       rwQ, rwD;
    logic [6:0] devQ, devD;
    logic [7:0] regQ, regD;
    logic [7:0] lenQ, lenD;
    logic [7:0] rxDataQ, rxDataD;
    logic       rxValidQ, rxValidD;
    logic       txAckQ, txAckD;
    logic       doneQ, doneD;
    logic       ackErrQ, ackErrD;

    logic isByte, isRead, hold, tick;

    assign isByte = (stateQ == StAddrW) || (stateQ == StReg) || (stateQ == StLen) ||
                    (stateQ == StWdata) || (stateQ == StAddrR) || (stateQ == StRdata);
    assign isRead = (stateQ == StRdata);

`ifdef I2C_MASTER_STRETCH_EN
    // Freeze at the first cycle of the SCL-high quarter until the pad really is high.
    assign hold = !sclIn && (qCntQ == 10'd0) &&
                  ((isByte && phaseQ == 2'd2) || (stateQ == StStop && phaseQ == 2'd1));
`else
    logic unusedSclIn;
    assign unusedSclIn = sclIn;
    assign hold = 1'b0;
`endif

    assign tick = (qCntQ == QuarterMax) && !hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ   <= StIdle;
            phaseQ   <= 2'd0;
            qCntQ    <= 10'd0;
            bitCntQ  <= 4'd0;
            byteCntQ <= 8'd0;
            shiftQ   <= 8'd0;
            rwQ      <= 1'b0;
            devQ     <= 7'd0;
            regQ     <= 8'd0;
            lenQ     <= 8'd0;
            rxDataQ  <= 8'd0;
            rxValidQ <= 1'b0;
            txAckQ   <= 1'b0;
            doneQ    <= 1'b0;
            ackErrQ  <= 1'b0;
        end else begin
            stateQ   <= stateD;
            phaseQ   <= phaseD;
            qCntQ    <= qCntD;
            bitCntQ  <= bitCntD;
            byteCntQ <= byteCntD;
            shiftQ   <= shiftD;
            rwQ      <= rwD;
            devQ     <= devD;
            regQ     <= regD;
            lenQ     <= lenD;
            rxDataQ  <= rxDataD;
            rxValidQ <= rxValidD;
            txAckQ   <= txAckD;
            doneQ    <= doneD;
            ackErrQ  <= ackErrD;
        end
    end

    always_comb begin
        stateD   = stateQ;
        phaseD   = phaseQ;
        qCntD    = qCntQ;
        bitCntD  = bitCntQ;
        byteCntD = byteCntQ;
        shiftD   = shiftQ;
        rwD      = rwQ;
        devD     = devQ;
        regD     = regQ;
        lenD     = lenQ;
        rxDataD  = rxDataQ;
        ackErrD  = ackErrQ;
        rxValidD = 1'b0;
        txAckD   = 1'b0;
        doneD    = 1'b0;

        if (stateQ != StIdle && !hold) begin
            qCntD = tick ? 10'd0 : qCntQ + 10'd1;
        end

        case (stateQ)
            StIdle: begin
                // The done cycle is still idle; a start there is dropped.
                if (start && !doneQ) begin
                    stateD  = StStart;
                    phaseD  = 2'd0;
                    qCntD   = 10'd0;
                    rwD     = rw;
                    devD    = devAddr;
                    regD    = regAddr;
                    lenD    = dataLen;
                    ackErrD = 1'b0;
                end
            end
            StStart: begin
                if (tick) begin
                    phaseD = phaseQ + 2'd1;
                    if (phaseQ == 2'd3) begin
                        stateD  = StAddrW;
                        bitCntD = 4'd0;
                        shiftD  = {devQ, 1'b0};
                    end
                end
            end
            StRstart: begin
                if (tick) begin
                    phaseD = phaseQ + 2'd1;
                    if (phaseQ == 2'd2) begin
                        stateD  = StAddrR;
                        phaseD  = 2'd0;
                        bitCntD = 4'd0;
                        shiftD  = {devQ, 1'b1};
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    phaseD = phaseQ + 2'd1;
                    if (phaseQ == 2'd2) begin
                        stateD = StIdle;
                        phaseD = 2'd0;
                        doneD  = 1'b1;
                    end
                end
            end
            default: begin
                if (tick) begin
                    phaseD = phaseQ + 2'd1;
                    if (phaseQ == 2'd2) begin
                        if (bitCntQ < 4'd8) begin
                            if (isRead) begin
                                shiftD = {shiftQ[6:0], sdaIn};
                                if (bitCntQ == 4'd7) begin
                                    rxDataD  = {shiftQ[6:0], sdaIn};
                                    rxValidD = 1'b1;
                                end
                            end
                        end else if (!isRead && sdaIn) begin
                            ackErrD = 1'b1;
                        end
                    end
                    if (phaseQ == 2'd3) begin
                        bitCntD = bitCntQ + 4'd1;
                        if (bitCntQ < 4'd8 && !isRead) begin
                            shiftD = {shiftQ[6:0], 1'b0};
                        end
                        if (bitCntQ == 4'd8) begin
                            bitCntD = 4'd0;
                            if (!isRead && ackErrQ) begin
                                stateD = StStop;
                            end else begin
                                case (stateQ)
                                    StAddrW: begin
                                        stateD = StReg;
                                        shiftD = regQ;
                                    end
                                    StReg: begin
                                        stateD = StLen;
                                        shiftD = lenQ;
                                    end
                                    StLen: begin
                                        if (lenQ == 8'd0) begin
                                            stateD = StStop;
                                        end else if (rwQ) begin
                                            stateD = StRstart;
                                        end else begin
                                            stateD   = StWdata;
                                            shiftD   = txData;
                                            txAckD   = 1'b1;
                                            byteCntD = lenQ;
                                        end
                                    end
                                    StWdata: begin
                                        if (byteCntQ <= 8'd1) begin
                                            stateD   = StStop;
                                            byteCntD = 8'd0;
                                        end else begin
                                            byteCntD = byteCntQ - 8'd1;
                                            shiftD   = txData;
                                            txAckD   = 1'b1;
                                        end
                                    end
                                    StAddrR: begin
                                        stateD   = StRdata;
                                        byteCntD = lenQ;
                                    end
                                    default: begin
                                        if (byteCntQ <= 8'd1) begin
                                            stateD   = StStop;
                                            byteCntD = 8'd0;
                                        end else begin
                                            byteCntD = byteCntQ - 8'd1;
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        sclOut = 1'b1;
        sdaOut = 1'b1;
        case (stateQ)
            StIdle: begin
                sclOut = 1'b1;
                sdaOut = 1'b1;
            end
            StStart: begin
                sdaOut = !phaseQ[1];
            end
            StRstart: begin
                sclOut = (phaseQ != 2'd0);
                sdaOut = (phaseQ != 2'd2);
            end
            StStop: begin
                sclOut = (phaseQ != 2'd0);
                sdaOut = (phaseQ == 2'd2);
            end
            default: begin
                sclOut = phaseQ[1];
                if (bitCntQ == 4'd8) begin
                    // Master ACKs every read byte but the last; released on write ACK slots.
                    sdaOut = isRead ? (byteCntQ <= 8'd1) : 1'b1;
                end else begin
                    sdaOut = isRead ? 1'b1 : shiftQ[7];
                end
            end
        endcase
    end

    assign busy    = (stateQ != StIdle);
    assign done    = doneQ;
    assign txAck   = txAckQ;
    assign rxData  = rxDataQ;
    assign rxValid = rxValidQ;
    assign ackErr  = ackErrQ;

endmodule

// File: tb/tb_i2c_master_engine.sv
// Directed bench for i2c_master_engine: open-drain bus model with an I2C slave and host.
`timescale 1ns/1ps
module tb_i2c_master_engine;

    localparam int unsigned CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] devAddr = 7'd0;
    logic [7:0] regAddr = 8'd0;
    logic [7:0] dataLen = 8'd0;
    logic [7:0] txData;
    logic       txAck, rxValid, busy, done, ackErr, sclOut, sdaOut;
    logic [7:0] rxData;
    logic       sclIn, sdaIn;
    logic       stretchLow = 1'b0;
    logic       slaveSda = 1'b1;

    assign sclIn = sclOut & ~stretchLow;
    assign sdaIn = sdaOut & slaveSda;

    i2c_master_engine #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .start(start), .rw(rw), .devAddr(devAddr), .regAddr(regAddr),
        .dataLen(dataLen), .txData(txData), .txAck(txAck), .rxData(rxData), .rxValid(rxValid),
        .busy(busy), .done(done), .ackErr(ackErr), .sclIn(sclIn), .sdaIn(sdaIn),
        .sclOut(sclOut), .sdaOut(sdaOut)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Host/slave model state, owned by the monitor except the configuration knobs.
    logic [7:0] wrData [4];
    logic [7:0] rdData [4];
    logic       nakAll = 1'b0;
    logic       stretchArm = 1'b0;
    int         clrGen = 0;

    int         clrSeen = 0;
    logic [7:0] busLog [16];
    logic [7:0] rxLog [8];
    logic       mAck [4];
    logic [7:0] curByte = 8'd0;
    int nBytes = 0, nStart = 0, nStop = 0, nTxAck = 0, nRxValid = 0, nDone = 0, nMAck = 0;
    int bitIdx = 0, rdIdx = 0, txIdx = 0, hiCnt = 0, hiMeas = 0, perMeas = 0;
    int lastRise = 0, cyc = 0, stretchCnt = 0;
    logic sclP = 1'b1, sdaP = 1'b1, sclOutP = 1'b1;
    logic slaveTx = 1'b0, firstByte = 1'b0, lastMAck = 1'b1, stretchUsed = 1'b0;

    always @(negedge clk) begin
        logic sclB, sdaB;
        cyc++;
        if (rst || clrGen != clrSeen) begin
            clrSeen = clrGen;
            nBytes = 0; nStart = 0; nStop = 0; nTxAck = 0; nRxValid = 0; nDone = 0; nMAck = 0;
            bitIdx = 0; rdIdx = 0; txIdx = 0; hiCnt = 0; hiMeas = 0; perMeas = 0;
            lastRise = cyc; stretchCnt = 0; stretchLow = 1'b0; stretchUsed = 1'b0;
            sclP = 1'b1; sdaP = 1'b1; sclOutP = 1'b1;
            slaveTx = 1'b0; slaveSda = 1'b1; firstByte = 1'b0; lastMAck = 1'b1;
            txData = wrData[0];
        end else begin
            if (stretchCnt > 0) stretchCnt--;
            if (stretchArm && !stretchUsed && !sclOutP && sclOut && nBytes == 1 && bitIdx == 3) begin
                stretchCnt = 20;
                stretchUsed = 1'b1;
            end
            stretchLow = (stretchCnt > 0);
            sclB = sclOut & ~stretchLow;
            sdaB = sdaOut & slaveSda;

            if (sclOut) hiCnt++;
            if (sclOutP && !sclOut) begin
                if (nBytes == 1 && bitIdx == 4) hiMeas = hiCnt;
                hiCnt = 0;
            end
            if (txAck) begin
                nTxAck++;
                txIdx++;
                txData = wrData[txIdx[1:0]];
            end
            if (rxValid) begin
                if (nRxValid < 8) rxLog[nRxValid[2:0]] = rxData;
                nRxValid++;
            end
            if (done) nDone++;

            if (sclP && sclB && sdaP && !sdaB) begin
                nStart++;
                bitIdx = 0; slaveTx = 1'b0; slaveSda = 1'b1; firstByte = 1'b1;
            end else if (sclP && sclB && !sdaP && sdaB) begin
                nStop++;
                slaveTx = 1'b0; slaveSda = 1'b1;
            end else if (!sclP && sclB) begin
                if (bitIdx == 4) perMeas = cyc - lastRise;
                lastRise = cyc;
                if (bitIdx < 8) begin
                    curByte = {curByte[6:0], sdaB};
                end else if (slaveTx) begin
                    lastMAck = sdaB;
                    if (nMAck < 4) mAck[nMAck[1:0]] = sdaB;
                    nMAck++;
                end
                bitIdx++;
            end else if (sclP && !sclB) begin
                if (bitIdx == 8) begin
                    if (slaveTx) begin
                        slaveSda = 1'b1;
                    end else begin
                        if (nBytes < 16) busLog[nBytes[3:0]] = curByte;
                        nBytes++;
                        slaveSda = nakAll;
                    end
                end else if (bitIdx == 9) begin
                    bitIdx = 0;
                    if (slaveTx) begin
                        rdIdx++;
                        if (lastMAck) slaveTx = 1'b0;
                    end else if (firstByte && curByte[0] && !nakAll) begin
                        slaveTx = 1'b1;
                        rdIdx = 0;
                    end
                    firstByte = 1'b0;
                    slaveSda = slaveTx ? rdData[rdIdx[1:0]][7] : 1'b1;
                end else if (slaveTx && bitIdx > 0 && bitIdx < 8) begin
                    slaveSda = rdData[rdIdx[1:0]][3'(7 - bitIdx)];
                end
            end
            sclP = sclB; sdaP = sdaB; sclOutP = sclOut;
        end
    end

    task automatic waitDone();
        int n = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkVal("done_seen", done, 1);
        checkVal("busy_at_done", busy, 0);
        if (!done) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic runTxn(input logic r, input logic [6:0] d, input logic [7:0] ra,
                          input logic [7:0] len);
        clrGen++;
        repeat (2) @(negedge clk);
        rw = r; devAddr = d; regAddr = ra; dataLen = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkVal("busy_after_start", busy, 1);
        waitDone();
    endtask

    initial begin
        int n;
        wrData[0] = 8'hA5; wrData[1] = 8'h3C; wrData[2] = 8'h00; wrData[3] = 8'h00;
        rdData[0] = 8'hBE; rdData[1] = 8'hEF; rdData[2] = 8'h00; rdData[3] = 8'h00;
        repeat (3) @(negedge clk);
        checkVal("rst_scl", sclOut, 1);
        checkVal("rst_sda", sdaOut, 1);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_done", done, 0);
        checkVal("rst_txack", txAck, 0);
        checkVal("rst_rxvalid", rxValid, 0);
        checkVal("rst_ackerr", ackErr, 0);
        checkVal("rst_rxdata", rxData, 8'h00);
        rst = 1'b0;

        // Write 2 bytes
        runTxn(1'b0, 7'h50, 8'h10, 8'd2);
        checkVal("wr_nbytes", nBytes, 5);
        checkVal("wr_b0", busLog[0], 8'hA0);
        checkVal("wr_b1", busLog[1], 8'h10);
        checkVal("wr_b2", busLog[2], 8'h02);
        checkVal("wr_b3", busLog[3], 8'hA5);
        checkVal("wr_b4", busLog[4], 8'h3C);
        checkVal("wr_nstart", nStart, 1);
        checkVal("wr_nstop", nStop, 1);
        checkVal("wr_txack", nTxAck, 2);
        checkVal("wr_done", nDone, 1);
        checkVal("wr_ackerr", ackErr, 0);
        checkVal("wr_period", perMeas, 4 * CLK_DIV);
        checkVal("wr_high", hiMeas, 2 * CLK_DIV);

        // Read 2 bytes with repeated start
        runTxn(1'b1, 7'h50, 8'h20, 8'd2);
        checkVal("rd_nbytes", nBytes, 4);
        checkVal("rd_b0", busLog[0], 8'hA0);
        checkVal("rd_b1", busLog[1], 8'h20);
        checkVal("rd_b2", busLog[2], 8'h02);
        checkVal("rd_b3", busLog[3], 8'hA1);
        checkVal("rd_nstart", nStart, 2);
        checkVal("rd_nrxvalid", nRxValid, 2);
        checkVal("rd_rx0", rxLog[0], 8'hBE);
        checkVal("rd_rx1", rxLog[1], 8'hEF);
        checkVal("rd_rxhold", rxData, 8'hEF);
        checkVal("rd_nmack", nMAck, 2);
        checkVal("rd_mack0", mAck[0], 0);
        checkVal("rd_mack1", mAck[1], 1);
        checkVal("rd_nstop", nStop, 1);
        checkVal("rd_done", nDone, 1);
        checkVal("rd_txack", nTxAck, 0);
        checkVal("rd_ackerr", ackErr, 0);

        // Address NAK
        nakAll = 1'b1;
        runTxn(1'b0, 7'h50, 8'h10, 8'd2);
        nakAll = 1'b0;
        checkVal("nak_nbytes", nBytes, 1);
        checkVal("nak_b0", busLog[0], 8'hA0);
        checkVal("nak_ackerr", ackErr, 1);
        checkVal("nak_nstop", nStop, 1);
        checkVal("nak_done", nDone, 1);
        checkVal("nak_txack", nTxAck, 0);

        // Zero-length read: no repeated start, no data
        runTxn(1'b1, 7'h50, 8'h05, 8'd0);
        checkVal("z_ackerr_clr", ackErr, 0);
        checkVal("z_nbytes", nBytes, 3);
        checkVal("z_b0", busLog[0], 8'hA0);
        checkVal("z_b1", busLog[1], 8'h05);
        checkVal("z_b2", busLog[2], 8'h00);
        checkVal("z_nstart", nStart, 1);
        checkVal("z_nrxvalid", nRxValid, 0);
        checkVal("z_nstop", nStop, 1);

        // Reset during the register byte
        clrGen++;
        repeat (2) @(negedge clk);
        rw = 1'b0; devAddr = 7'h50; regAddr = 8'h33; dataLen = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(nBytes == 1 && bitIdx >= 3) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkVal("mid_reached_reg", (nBytes == 1 && bitIdx >= 3), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkVal("mid_scl", sclOut, 1);
        checkVal("mid_sda", sdaOut, 1);
        checkVal("mid_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        wrData[0] = 8'h5A;
        runTxn(1'b0, 7'h50, 8'h10, 8'd1);
        checkVal("post_nbytes", nBytes, 4);
        checkVal("post_b0", busLog[0], 8'hA0);
        checkVal("post_b1", busLog[1], 8'h10);
        checkVal("post_b2", busLog[2], 8'h01);
        checkVal("post_b3", busLog[3], 8'h5A);
        checkVal("post_done", nDone, 1);
        checkVal("post_txack", nTxAck, 1);
        checkVal("post_ackerr", ackErr, 0);

`ifdef I2C_MASTER_STRETCH_EN
        // Slave holds SCL low for 20 clk on bit 3 of the register byte
        stretchArm = 1'b1;
        runTxn(1'b0, 7'h50, 8'h96, 8'd0);
        stretchArm = 1'b0;
        checkVal("st_nbytes", nBytes, 3);
        checkVal("st_b1", busLog[1], 8'h96);
        checkVal("st_high", hiMeas, 2 * CLK_DIV + 20);
        checkVal("st_done", nDone, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
